// File: rtl/uart_rx_cfg_if.sv
// Serial receive channel bundle: raw line and enable in, received word and status out.
// The receiver uses the slave modport; whoever drives the line and consumes words uses master.
`timescale 1ns/1ps
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic                 rx_enable_signal;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done_signal;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output rx_in, rx_enable_signal,
    input  rx_data, rx_done_signal, parity_err, frame_err
  );

  modport slave (
    input  rx_in, rx_enable_signal,
    output rx_data, rx_done_signal, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised line input, false-start rejection,
// optional parity and one or two stop bits, with parity/framing error flags.
`timescale 1ns/1ps
module uart_rx_cfg #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD        = 1000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.slave  rx_bus
);

  localparam int DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx_cfg: clock-to-baud ratio must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_width_check
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_parity_check
      $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
      $error("uart_rx_cfg: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_prev_reg;
  state_t                 state_reg;
  logic [CW-1:0]          cnt_reg;
  logic [3:0]             bit_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_err_pend_reg;
  logic                   frame_err_pend_reg;
  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   done_reg;
  logic                   parity_err_reg;
  logic                   frame_err_reg;

  logic rx_s;
  logic falling_edge;
  logic bit_tick;
  logic par_xor;

  assign rx_s         = sync_reg[SYNC_STAGES-1];
  assign falling_edge = rx_prev_reg & ~rx_s;
  assign bit_tick     = (cnt_reg == CNT_LAST);
  assign par_xor      = ^{shift_reg, rx_s};

  // Idle-high reset value keeps a spurious start edge from appearing out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx_bus.rx_in};
      rx_prev_reg <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      cnt_reg            <= '0;
      bit_cnt_reg        <= '0;
      shift_reg          <= '0;
      par_err_pend_reg   <= 1'b0;
      frame_err_pend_reg <= 1'b0;
      rx_data_reg        <= '0;
      done_reg           <= 1'b0;
      parity_err_reg     <= 1'b0;
      frame_err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (falling_edge && rx_bus.rx_enable_signal) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg <= '0;
            if (rx_s) begin
              state_reg <= IDLE;
            end else begin
              state_reg          <= DATA;
              bit_cnt_reg        <= '0;
              par_err_pend_reg   <= 1'b0;
              frame_err_pend_reg <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == LAST_DATA) begin
              bit_cnt_reg <= '0;
              state_reg   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        PARITY: begin
          if (bit_tick) begin
            cnt_reg          <= '0;
            par_err_pend_reg <= (PARITY_MODE == 1) ? ~par_xor : par_xor;
            state_reg        <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt_reg <= '0;
            // Publishing at the last stop centre leaves half a bit to catch the next start edge.
            if (bit_cnt_reg == LAST_STOP) begin
              rx_data_reg    <= shift_reg;
              parity_err_reg <= par_err_pend_reg;
              frame_err_reg  <= frame_err_pend_reg | ~rx_s;
              done_reg       <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              frame_err_pend_reg <= frame_err_pend_reg | ~rx_s;
              bit_cnt_reg        <= bit_cnt_reg + 4'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_bus.rx_data        = rx_data_reg;
  assign rx_bus.rx_done_signal = done_reg;
  assign rx_bus.parity_err     = parity_err_reg;
  assign rx_bus.frame_err      = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receivers with different frame formats, driven by a
// frame-level line model; every received word is matched against a queue of expected frames.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int PERIOD = 10;
  localparam int NCH    = 4;

  // ch0: 8N1 div 50, ch1: 8E1 div 50, ch2: 8N2 div 50, ch3: 9O2 div 16
  int nb_c [NCH] = '{8, 8, 8, 9};
  int pm_c [NCH] = '{0, 2, 0, 1};
  int sb_c [NCH] = '{1, 1, 2, 2};
  int dv_c [NCH] = '{50, 50, 50, 16};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] rx_line = '1;
  logic [NCH-1:0] en = '1;

  always #(PERIOD / 2) clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_rx_cfg_if #(.DATA_BITS(9)) if3 ();

  assign if0.rx_in = rx_line[0];  assign if0.rx_enable_signal = en[0];
  assign if1.rx_in = rx_line[1];  assign if1.rx_enable_signal = en[1];
  assign if2.rx_in = rx_line[2];  assign if2.rx_enable_signal = en[2];
  assign if3.rx_in = rx_line[3];  assign if3.rx_enable_signal = en[3];

  uart_rx_cfg dut0 (.clk(clk), .rst(rst), .rx_bus(if0));
  uart_rx_cfg #(.PARITY_MODE(2)) dut1 (.clk(clk), .rst(rst), .rx_bus(if1));
  uart_rx_cfg #(.STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .rx_bus(if2));
  uart_rx_cfg #(.BAUD(3125000), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(2))
    dut3 (.clk(clk), .rst(rst), .rx_bus(if3));

  logic [NCH-1:0] done_w;
  logic [NCH-1:0] pe_w;
  logic [NCH-1:0] fe_w;
  logic [8:0]     data_w [NCH];

  assign done_w = {if3.rx_done_signal, if2.rx_done_signal, if1.rx_done_signal, if0.rx_done_signal};
  assign pe_w   = {if3.parity_err, if2.parity_err, if1.parity_err, if0.parity_err};
  assign fe_w   = {if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
  assign data_w[0] = {1'b0, if0.rx_data};
  assign data_w[1] = {1'b0, if1.rx_data};
  assign data_w[2] = {1'b0, if2.rx_data};
  assign data_w[3] = if3.rx_data;

  typedef struct {
    int         ch;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         lat;
    longint     t0;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses [NCH] = '{0, 0, 0, 0};
  logic [NCH-1:0] prev_done = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic drive_bit(input int ch, input logic v);
    rx_line[ch] = v;
    repeat (dv_c[ch]) @(negedge clk);
  endtask

  // Frame-level line model; call on a negedge. Expected result comes from the frame rules.
  task automatic send_frame(input int ch, input logic [8:0] d, input bit bad_par,
                            input bit stop_low, input bit push);
    logic [8:0] dm;
    logic       pbit;
    exp_t       e;
    dm   = d & 9'((1 << nb_c[ch]) - 1);
    pbit = logic'($countones(dm) % 2) ^ (pm_c[ch] == 1) ^ bad_par;
    if (push) begin
      e.ch  = ch;
      e.d   = dm;
      e.pe  = (pm_c[ch] != 0) && bad_par;
      e.fe  = stop_low;
      e.lat = 2 + 1 + dv_c[ch] / 2 + dv_c[ch] * (nb_c[ch] + (pm_c[ch] != 0 ? 1 : 0) + sb_c[ch]);
      e.t0  = longint'($time);
      exp_q.push_back(e);
      $display("send ch%0d data=0x%0h bad_par=%0d stop_low=%0d", ch, dm, bad_par, stop_low);
    end
    drive_bit(ch, 1'b0);
    for (int i = 0; i < nb_c[ch]; i++) drive_bit(ch, dm[i]);
    if (pm_c[ch] != 0) drive_bit(ch, pbit);
    for (int s = 0; s < sb_c[ch]; s++) drive_bit(ch, !stop_low);
    rx_line[ch] = 1'b1;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_queue", 32'(exp_q.size()), 0);
    repeat (5) @(negedge clk);
  endtask

  // Scoreboard: each pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (done_w[c]) begin
        exp_t   e;
        longint lat;
        pulses[c]++;
        chk("pulse_width", 32'(prev_done[c]), 0);
        chk("frame_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          lat = (longint'($time) - e.t0) / PERIOD;
          $display("recv ch%0d data=0x%0h pe=%0d fe=%0d latency=%0d", c, data_w[c], pe_w[c], fe_w[c], lat);
          chk("channel", 32'(c), 32'(e.ch));
          chk("rx_data", 32'(data_w[c]), 32'(e.d));
          chk("parity_err", 32'(pe_w[c]), 32'(e.pe));
          chk("frame_err", 32'(fe_w[c]), 32'(e.fe));
          chk("latency_window", 32'(lat >= e.lat - 1 && lat <= e.lat + 1), 1);
        end
      end
      prev_done[c] = done_w[c];
    end
  end

  initial begin
    #(PERIOD * 90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk("reset_data", 32'(data_w[c]), 0);
      chk("reset_flags", 32'({done_w[c], pe_w[c], fe_w[c]}), 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 basic frame
    send_frame(0, 9'hA5, 0, 0, 1);
    wait_idle();

    // even parity: wrong then right parity bit
    send_frame(1, 9'h03, 1, 0, 1);
    wait_idle();
    send_frame(1, 9'h03, 0, 0, 1);
    wait_idle();

    // 10-cycle low glitch must be rejected
    p = pulses[0];
    rx_line[0] = 1'b0;
    repeat (10) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_pulses", 32'(pulses[0] - p), 0);
    chk("glitch_data", 32'(data_w[0]), 32'h0A5);
    chk("glitch_flags", 32'({pe_w[0], fe_w[0]}), 0);
    send_frame(0, 9'h5A, 0, 0, 1);
    wait_idle();

    // framing error still delivers data
    send_frame(0, 9'h3C, 0, 1, 1);
    repeat (dv_c[0]) @(negedge clk);
    wait_idle();

    // back-to-back frames, one and two stop bits
    send_frame(0, 9'h11, 0, 0, 1);
    send_frame(0, 9'hEE, 0, 0, 1);
    wait_idle();
    send_frame(2, 9'h11, 0, 0, 1);
    send_frame(2, 9'hEE, 0, 0, 1);
    wait_idle();

    // break: line held low well past a frame
    p = pulses[0];
    exp_q.push_back('{ch: 0, d: 9'h000, pe: 1'b0, fe: 1'b1, lat: 478, t0: longint'($time)});
    $display("send ch0 break");
    rx_line[0] = 1'b0;
    repeat (1500) @(negedge clk);
    chk("break_pulses", 32'(pulses[0] - p), 1);
    rx_line[0] = 1'b1;
    repeat (100) @(negedge clk);
    chk("break_no_restart", 32'(pulses[0] - p), 1);
    wait_idle();

    // reset after the 4th data bit
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rx_line[0] = 1'b1;
    chk("midrst_data", 32'(data_w[0]), 0);
    chk("midrst_flags", 32'({done_w[0], pe_w[0], fe_w[0]}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(0, 9'h7E, 0, 0, 1);
    wait_idle();

    // enable low before the start edge: frame ignored
    p = pulses[0];
    en[0] = 1'b0;
    send_frame(0, 9'h81, 0, 0, 0);
    repeat (100) @(negedge clk);
    chk("disabled_pulses", 32'(pulses[0] - p), 0);
    chk("disabled_data", 32'(data_w[0]), 32'h07E);
    en[0] = 1'b1;
    repeat (20) @(negedge clk);

    // randomized frames on every channel
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < 8; k++) begin
        logic [8:0] d;
        bit         bp;
        bit         sl;
        int         gap;
        d   = 9'($urandom);
        bp  = ($urandom_range(0, 3) == 0);
        sl  = ($urandom_range(0, 5) == 0);
        gap = $urandom_range(0, 20);
        if (sl) gap = gap + dv_c[c];
        send_frame(c, d, bp, sl, 1);
        repeat (gap) @(negedge clk);
      end
      wait_idle();
    end

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
